data_mem_bridge: RTL and testbench

Bridges the CPU core's single-cycle data port (`data_addr`, `data_out`, `data_read`, `data_write`, `data_in`) to a multi-cycle data memory that uses a req/ack handshake. It sits directly downstream of the core. Each access is latched into the bridge, and the core is stalled until the access completes. The bridge also flags misaligned or conflicting requests and memory timeouts.

---
 rtl/dmb_pkg.sv | 15 +
 rtl/dmb_wbuf.sv | 40 ++++
 rtl/data_mem_bridge.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_bridge.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmb_pkg.sv
// rtl/dmb_pkg.sv - shared types and constants for data_mem_bridge
package dmb_pkg;

    localparam int DMB_DATA_W  = 32;
    localparam int DMB_TIMEOUT = 255;

    localparam logic [1:0] DMB_ALIGNED = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } dmb_state_e;

endpackage

// File: rtl/dmb_wbuf.sv
// rtl/dmb_wbuf.sv - single-entry posted write buffer (used only with DMB_WRITE_BUFFER_EN)
module dmb_wbuf
    import dmb_pkg::*;
#(
    parameter int DATA_W = DMB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - stalls the core's data port across a req/ack data memory
// Optional posted write buffer enabled by defining DMB_WRITE_BUFFER_EN.
module data_mem_bridge
    import dmb_pkg::*;
#(
    parameter int DATA_W  = DMB_DATA_W,
    parameter int TIMEOUT = DMB_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmb_state_e        r_state;
    dmb_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_fault;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic              w_req;
    logic              w_bad;
    logic              w_stall;
    logic              w_launch;
    logic              w_finish;
    logic              w_fault_set;
    logic              w_fail_rdata;
    logic              w_drain_busy;
    logic              w_launch_we;
    logic [DATA_W-1:0] w_launch_addr;
    logic [DATA_W-1:0] w_launch_data;

    assign w_req = cpu_read | cpu_write;
    assign w_bad = (cpu_read & cpu_write) | (cpu_addr[1:0] != DMB_ALIGNED);

`ifdef DMB_WRITE_BUFFER_EN
    logic              r_drain;
    logic              w_wb_valid;
    logic              w_wb_push;
    logic              w_drain_go;
    logic [DATA_W-1:0] w_wb_addr;
    logic [DATA_W-1:0] w_wb_data;

    dmb_wbuf #(.DATA_W(DATA_W)) u_wbuf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wb_push),
        .i_addr  ({cpu_addr[DATA_W-1:2], DMB_ALIGNED}),
        .i_data  (cpu_wdata),
        .i_pop   (w_finish & r_drain),
        .o_valid (w_wb_valid),
        .o_addr  (w_wb_addr),
        .o_data  (w_wb_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_drain <= 1'b0;
        else if (w_drain_go) r_drain <= 1'b1;
        else if (w_finish)   r_drain <= 1'b0;
    end

    assign w_drain_busy = r_drain;
`else
    assign w_drain_busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_stall       = 1'b0;
        w_launch      = 1'b0;
        w_finish      = 1'b0;
        w_fault_set   = 1'b0;
        w_fail_rdata  = 1'b0;
        w_launch_we   = cpu_write;
        w_launch_addr = {cpu_addr[DATA_W-1:2], DMB_ALIGNED};
        w_launch_data = cpu_wdata;
`ifdef DMB_WRITE_BUFFER_EN
        w_wb_push     = 1'b0;
        w_drain_go    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef DMB_WRITE_BUFFER_EN
                // A pending posted write always drains before the core is served.
                if (w_wb_valid) begin
                    w_stall       = w_req;
                    w_launch      = 1'b1;
                    w_drain_go    = 1'b1;
                    w_launch_we   = 1'b1;
                    w_launch_addr = w_wb_addr;
                    w_launch_data = w_wb_data;
                    w_state_nxt   = ST_BUSY;
                end else if (w_req && !w_bad && cpu_write) begin
                    w_wb_push = 1'b1;
                end else
`endif
                if (w_req) begin
                    w_stall = 1'b1;
                    if (w_bad) begin
                        w_fault_set  = 1'b1;
                        w_fail_rdata = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_launch    = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_stall = w_drain_busy ? w_req : 1'b1;
                // Ack in the final counted cycle still wins over the timeout.
                if (mem_ack || (r_cnt == CNT_LAST)) begin
                    w_finish    = 1'b1;
                    w_fault_set = ~mem_ack;
                    w_state_nxt = w_drain_busy ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fault     <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_fault <= w_fault_set;
            if (w_launch) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_launch_we;
                r_mem_addr  <= w_launch_addr;
                r_mem_wdata <= w_launch_data;
            end else if (w_finish) begin
                r_mem_req <= 1'b0;
            end
            r_cnt <= ((r_state == ST_BUSY) && !w_finish) ? r_cnt + 1'b1 : '0;
            if (w_fail_rdata)
                r_cpu_rdata <= '0;
            else if (w_finish && !w_drain_busy)
                r_cpu_rdata <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
        end
    end

    // The stall gates the core clock, so it must drop the instant reset asserts.
    assign cpu_stall = w_stall & ~reset;
    assign cpu_fault = r_fault;
    assign cpu_rdata = r_cpu_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - randomized self-checking bench for data_mem_bridge (blocking-store build)
module tb_data_mem_bridge;

    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_read = 1'b0;
    logic          cpu_write = 1'b0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          cpu_fault;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    data_mem_bridge #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_fault (cpu_fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'hA5A5_3C3C;
    endfunction

    // One core access; the memory responder acks on BUSY cycle ack_dly+1 (never if that exceeds TMO).
    task automatic run_access(input string name, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wdata, input int ack_dly);
        int          stall_n, req_n, cyc, exp_stall, exp_req;
        bit          done, bad_req, ack_ok, exp_fault, unstable;
        logic        got_fault, seen_we;
        logic [31:0] waddr, exp_rdata, got_rdata, seen_addr, seen_wdata;
        stall_n = 0; req_n = 0; cyc = 0; done = 0; unstable = 0;
        got_fault = 0; got_rdata = 0; seen_we = 0; seen_addr = 0; seen_wdata = 0;
        exp_rdata = 0;
        waddr   = {addr[31:2], 2'b00};
        bad_req = (rd && wr) || (addr[1:0] != 2'b00);
        ack_ok  = !bad_req && (ack_dly < TMO);
        if (bad_req) begin
            exp_stall = 1; exp_req = 0; exp_fault = 1;
        end else if (ack_ok) begin
            exp_stall = 2 + ack_dly; exp_req = ack_dly + 1; exp_fault = 0;
            if (rd) exp_rdata = ref_mem.exists(waddr) ? ref_mem[waddr] : fill(waddr);
            else    ref_mem[waddr] = wdata;
        end else begin
            exp_stall = 1 + TMO; exp_req = TMO; exp_fault = 1;
        end

        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
        while (!done) begin
            #1;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
                end else if (mem_addr !== seen_addr || mem_we !== seen_we || mem_wdata !== seen_wdata) begin
                    unstable = 1;
                end
                mem_ack = (req_n == ack_dly + 1);
                if (mem_ack && mem_we) mem_store[mem_addr] = mem_wdata;
                mem_rdata = mem_ack ? (mem_store.exists(mem_addr) ? mem_store[mem_addr] : fill(mem_addr))
                                    : $urandom;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
            if (cpu_stall) begin
                stall_n++;
            end else begin
                done = 1; got_fault = cpu_fault; got_rdata = cpu_rdata;
            end
            cyc++;
            if (!done && cyc > 40) begin
                chk({name, "_bound"}, 1, 0);
                done = 1;
            end
            @(negedge clk);
        end
        cpu_read = 0; cpu_write = 0; mem_ack = 0;

        chk({name, "_stall"}, stall_n, exp_stall);
        chk({name, "_reqcyc"}, req_n, exp_req);
        chk({name, "_fault"}, got_fault, exp_fault);
        chk({name, "_rdata"}, got_rdata, exp_rdata);
        if (exp_req > 0) begin
            chk({name, "_maddr"}, seen_addr, waddr);
            chk({name, "_mwe"}, seen_we, wr);
            chk({name, "_stable"}, unstable, 0);
            if (wr) chk({name, "_mwdata"}, seen_wdata, wdata);
        end
        #1;
        chk({name, "_idle_fault"}, cpu_fault, 0);
        chk({name, "_idle_stall"}, cpu_stall, 0);
        chk({name, "_idle_rdata"}, cpu_rdata, exp_rdata);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [31:0] a;

        @(negedge clk);
        cpu_read = 1;
        #1;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_fault", cpu_fault, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        cpu_read = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        mem_store[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100]   = 32'hDEADBEEF;
        run_access("rd100", 1, 0, 32'h100, 32'h0, 2);
        run_access("wr200", 0, 1, 32'h200, 32'h12345678, 0);
        run_access("misal", 1, 0, 32'h103, 32'h0, 0);
        run_access("both", 1, 1, 32'h200, 32'h0, 0);
        run_access("tmo", 1, 0, 32'h300, 32'h0, TMO + 2);
        run_access("acklast", 1, 0, 32'h200, 32'h0, TMO - 1);

        cpu_read = 1; cpu_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstmid_pre_req", mem_req, 1);
        reset = 1;
        #1;
        chk("rstmid_req", mem_req, 0);
        chk("rstmid_stall", cpu_stall, 0);
        chk("rstmid_fault", cpu_fault, 0);
        @(negedge clk);
        cpu_read = 0; reset = 0; mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        #1;
        chk("late_ack_stall", cpu_stall, 0);
        @(negedge clk);
        mem_ack = 0;
        #1;
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_rdata", cpu_rdata, 0);
        chk("late_ack_fault", cpu_fault, 0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            a = 32'h1000 + 4 * $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_access($sformatf("rnd%0d", i), k <= 5, (k == 0) || (k >= 6), a, $urandom,
                       $urandom_range(0, TMO + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
